smc_phase_decoder: RTL and testbench

//  Receive-side counterpart of the 4-phase stepper coil driver. Watches the

---
 rtl/smc_phase_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_smc_phase_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/smc_phase_decoder.sv
// -----------------------------------------------------------------------------
// smc_phase_decoder
//
// Receive-side decoder for a 4-phase stepper coil pattern. Watches smc[3:0],
// reconstructs step events and direction, keeps a signed (wrapping) position
// count and raises sticky flags for illegal patterns and skipped phases.
//
// Phase codes: P1=1001, P2=0011, P3=0110, P4=1100, OFF=0000, anything else is
// illegal. Forward order is P1->P2->P3->P4->P1.
//
// smc is registered into smc_q; the decoder acts on smc_q and all outputs are
// registered, so a pattern change is visible on the outputs two edges later.
//
// Optional feature (compile-time macro SMC_DEBOUNCE_EN):
//   When defined, smc_q must hold the same value for DEB_CYC consecutive
//   cycles before the decoder acts on it (once per stable run). Shorter
//   glitches are ignored. Latency becomes DEB_CYC+1 edges.
//   When undefined, every sampled smc_q is acted on and DEB_CYC is unused.
//
// Parameters:
//   POS_W    width of the signed position counter
//   DEB_CYC  debounce hold length in cycles (>=1, SMC_DEBOUNCE_EN only)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   smc          coil pattern under observation
//   clr          synchronous clear of position and error flags
//   step_pulse   one-cycle pulse per decoded step
//   dir_out      direction of the last step (1 = forward, 0 = reverse)
//   position     signed step count
//   phase        last accepted phase index 0..3 (P1..P4)
//   locked       high while tracking a valid phase sequence
//   err_illegal  sticky: a non-phase, non-zero pattern was seen
//   err_skip     sticky: a jump to the opposite phase was seen
// -----------------------------------------------------------------------------
module smc_phase_decoder #(
    parameter int POS_W   = 16,
    parameter int DEB_CYC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              smc,
    input  logic                    clr,
    output logic                    step_pulse,
    output logic                    dir_out,
    output logic signed [POS_W-1:0] position,
    output logic [1:0]              phase,
    output logic                    locked,
    output logic                    err_illegal,
    output logic                    err_skip
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              smc_q;
    logic                    act;

    logic                    pat_is_off;
    logic                    pat_is_phase;
    logic [1:0]              pat_idx;
    logic [1:0]              idx_diff;

    logic                    step_d;
    logic                    dir_d;
    logic signed [POS_W-1:0] pos_d;
    logic [1:0]              phase_d;
    logic                    eil_d;
    logic                    esk_d;

    // Input sampling register.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its sources, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smc_q <= 4'b0000;
        end else begin
            smc_q <= smc;
        end
    end

`ifdef SMC_DEBOUNCE_EN
    // hold_cnt counts how many edges smc_q has kept its current value.
    // The decoder acts exactly once, on the edge where the count equals
    // DEB_CYC; afterwards it parks at DEB_CYC+1 until smc_q changes again.
    localparam int               CNT_W    = $clog2(DEB_CYC + 2);
    localparam logic [CNT_W-1:0] CNT_ACT  = CNT_W'(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_CYC + 1);

    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // smc_q resets to OFF, which needs no action: start already spent.
            hold_cnt <= CNT_DONE;
        end else if (smc != smc_q) begin
            hold_cnt <= CNT_W'(1);
        end else if (hold_cnt != CNT_DONE) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    assign act = (hold_cnt == CNT_ACT);
`else
    logic deb_cyc_unused;
    assign deb_cyc_unused = (DEB_CYC < 1);
    assign act            = 1'b1;
`endif

    // Pattern decode of the sampled coil state.
    always_comb begin
        pat_is_off   = (smc_q == 4'b0000);
        pat_is_phase = 1'b1;
        pat_idx      = 2'd0;
        case (smc_q)
            4'b1001: pat_idx = 2'd0;
            4'b0011: pat_idx = 2'd1;
            4'b0110: pat_idx = 2'd2;
            4'b1100: pat_idx = 2'd3;
            default: pat_is_phase = 1'b0;
        endcase
    end

    // Modulo-4 distance from the current phase: 1 = forward, 3 = reverse,
    // 2 = opposite phase (a skipped step), 0 = unchanged.
    assign idx_diff = pat_idx - phase;

    // Next-state and next-output logic.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        dir_d   = dir_out;
        pos_d   = position;
        phase_d = phase;
        eil_d   = err_illegal;
        esk_d   = err_skip;

        if (act) begin
            case (state_q)
                IDLE: begin
                    if (pat_is_phase) begin
                        // Homing: adopt the phase without counting a step.
                        state_d = TRACK;
                        phase_d = pat_idx;
                    end else if (!pat_is_off) begin
                        state_d = ERR;
                        eil_d   = 1'b1;
                    end
                end
                TRACK: begin
                    if (pat_is_phase) begin
                        phase_d = pat_idx;
                        case (idx_diff)
                            2'd1: begin
                                step_d = 1'b1;
                                dir_d  = 1'b1;
                                pos_d  = position + POS_W'(1);
                            end
                            2'd3: begin
                                step_d = 1'b1;
                                dir_d  = 1'b0;
                                pos_d  = position - POS_W'(1);
                            end
                            2'd2:    esk_d = 1'b1;
                            default: ;
                        endcase
                    end else if (pat_is_off) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ERR;
                        eil_d   = 1'b1;
                    end
                end
                ERR: begin
                    if (pat_is_phase) begin
                        state_d = TRACK;
                        phase_d = pat_idx;
                    end else if (pat_is_off) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Clear wins over any same-cycle count or error update; the step
        // pulse, direction, phase and FSM state still advance normally.
        if (clr) begin
            pos_d = '0;
            eil_d = 1'b0;
            esk_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            step_pulse  <= 1'b0;
            dir_out     <= 1'b0;
            position    <= '0;
            phase       <= 2'd0;
            locked      <= 1'b0;
            err_illegal <= 1'b0;
            err_skip    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_pulse  <= step_d;
            dir_out     <= dir_d;
            position    <= pos_d;
            phase       <= phase_d;
            locked      <= (state_d == TRACK);
            err_illegal <= eil_d;
            err_skip    <= esk_d;
        end
    end

endmodule

// File: tb/tb_smc_phase_decoder.sv
// -----------------------------------------------------------------------------
// tb_smc_phase_decoder
//
// Directed-vector bench for smc_phase_decoder (POS_W = 4 so wrap-around is
// reachable in a few steps). The stimulus process drives coil patterns and
// pushes the hand-computed expected output snapshot (tagged with the cycle it
// must appear on) plus any expected step event into queues. A separate
// monitor pops and compares: snapshots when their cycle arrives, step events
// whenever the DUT raises step_pulse.
// -----------------------------------------------------------------------------
module tb_smc_phase_decoder;

    localparam int POS_W   = 4;
    localparam int DEB_CYC = 4;
`ifdef SMC_DEBOUNCE_EN
    localparam int LAT = DEB_CYC + 1;
`else
    localparam int LAT = 2;
`endif

    logic                    clk;
    logic                    reset;
    logic [3:0]              smc;
    logic                    clr;
    logic                    step_pulse;
    logic                    dir_out;
    logic signed [POS_W-1:0] position;
    logic [1:0]              phase;
    logic                    locked;
    logic                    err_illegal;
    logic                    err_skip;

    // {step, dir, position, phase, locked, err_illegal, err_skip}
    typedef struct packed {
        logic       step;
        logic       dir;
        logic [3:0] pos;
        logic [1:0] ph;
        logic       lock;
        logic       eil;
        logic       esk;
    } obs_t;

    typedef struct {
        int    tag;
        string name;
        obs_t  exp;
    } snap_t;

    typedef struct {
        string      name;
        logic       dir;
        logic [3:0] pos;
    } step_t;

    snap_t snap_q[$];
    step_t step_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    smc_phase_decoder #(
        .POS_W   (POS_W),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .smc         (smc),
        .clr         (clr),
        .step_pulse  (step_pulse),
        .dir_out     (dir_out),
        .position    (position),
        .phase       (phase),
        .locked      (locked),
        .err_illegal (err_illegal),
        .err_skip    (err_skip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t sample();
        return {step_pulse, dir_out, position, phase, locked, err_illegal, err_skip};
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares snapshots on their due cycle and step events on
    // every step_pulse the DUT presents.
    always @(negedge clk) begin : monitor
        snap_t s;
        step_t st;
        if (reset) begin
            while (snap_q.size() > 0 && snap_q[0].tag <= cyc) begin
                s = snap_q.pop_front();
                check(s.name, 32'(sample()), 32'(s.exp));
            end
            if (step_pulse) begin
                if (step_q.size() == 0) begin
                    check("unexpected_step", 32'(1), 32'(0));
                end else begin
                    st = step_q.pop_front();
                    check({st.name, "_step"}, 32'({dir_out, position}), 32'({st.dir, st.pos}));
                end
            end
        end
    end

    // Drive one pattern (optionally with clr on the acting edge) and queue
    // the expected outputs for the edge on which the decoder acts on it.
    task automatic apply(input logic [3:0] p, input logic c, input string nm,
                         input logic st, input logic d, input logic [3:0] pos,
                         input logic [1:0] ph, input logic lk,
                         input logic ei, input logic es);
        snap_t s;
        step_t e;
        @(negedge clk);
        smc   = p;
        s.tag = cyc + LAT;
        s.name = nm;
        s.exp = {st, d, pos, ph, lk, ei, es};
        snap_q.push_back(s);
        if (st) begin
            e.name = nm;
            e.dir  = d;
            e.pos  = pos;
            step_q.push_back(e);
        end
        repeat (LAT - 1) @(negedge clk);
        clr = c;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b0;
        smc   = 4'b0000;
        clr   = 1'b0;
        #2;
        check("reset_state", 32'(sample()), 32'(0));
        @(negedge clk);
        reset = 1'b1;

        //     pattern  clr  name           st dir pos    ph  lk eil esk
        // Homing from IDLE.
        apply(4'b0000, 1'b0, "idle_off",    0, 0, 4'h0, 0, 0, 0, 0);
        apply(4'b1001, 1'b0, "home_p1",     0, 0, 4'h0, 0, 1, 0, 0);
        // Forward full revolution, then two reverse steps.
        apply(4'b0011, 1'b0, "fwd_p2",      1, 1, 4'h1, 1, 1, 0, 0);
        apply(4'b0110, 1'b0, "fwd_p3",      1, 1, 4'h2, 2, 1, 0, 0);
        apply(4'b1100, 1'b0, "fwd_p4",      1, 1, 4'h3, 3, 1, 0, 0);
        apply(4'b1001, 1'b0, "fwd_p1",      1, 1, 4'h4, 0, 1, 0, 0);
        apply(4'b1100, 1'b0, "rev_p4",      1, 0, 4'h3, 3, 1, 0, 0);
        apply(4'b0110, 1'b0, "rev_p3",      1, 0, 4'h2, 2, 1, 0, 0);
        apply(4'b0110, 1'b0, "hold_p3",     0, 0, 4'h2, 2, 1, 0, 0);
        // Back to P1, then skip, illegal, recovery and clear.
        apply(4'b0011, 1'b0, "rev_p2",      1, 0, 4'h1, 1, 1, 0, 0);
        apply(4'b1001, 1'b0, "rev_p1",      1, 0, 4'h0, 0, 1, 0, 0);
        apply(4'b0110, 1'b0, "skip_p3",     0, 0, 4'h0, 2, 1, 0, 1);
        apply(4'b1111, 1'b0, "illegal",     0, 0, 4'h0, 2, 0, 1, 1);
        apply(4'b0011, 1'b0, "err_to_p2",   0, 0, 4'h0, 1, 1, 1, 1);
        apply(4'b0110, 1'b0, "fwd_flagged", 1, 1, 4'h1, 2, 1, 1, 1);
        apply(4'b0110, 1'b1, "clr_flags",   0, 1, 4'h0, 2, 1, 0, 0);
        // Forward to +7, then wrap to -8 and back to +7.
        apply(4'b1100, 1'b0, "w_pos1",      1, 1, 4'h1, 3, 1, 0, 0);
        apply(4'b1001, 1'b0, "w_pos2",      1, 1, 4'h2, 0, 1, 0, 0);
        apply(4'b0011, 1'b0, "w_pos3",      1, 1, 4'h3, 1, 1, 0, 0);
        apply(4'b0110, 1'b0, "w_pos4",      1, 1, 4'h4, 2, 1, 0, 0);
        apply(4'b1100, 1'b0, "w_pos5",      1, 1, 4'h5, 3, 1, 0, 0);
        apply(4'b1001, 1'b0, "w_pos6",      1, 1, 4'h6, 0, 1, 0, 0);
        apply(4'b0011, 1'b0, "w_pos7",      1, 1, 4'h7, 1, 1, 0, 0);
        apply(4'b0110, 1'b0, "wrap_neg8",   1, 1, 4'h8, 2, 1, 0, 0);
        apply(4'b0011, 1'b0, "wrap_pos7",   1, 0, 4'h7, 1, 1, 0, 0);
        // clr coincident with a step and with an illegal pattern.
        apply(4'b0110, 1'b1, "clr_step",    1, 1, 4'h0, 2, 1, 0, 0);
        apply(4'b1111, 1'b1, "clr_illegal", 0, 1, 4'h0, 2, 0, 0, 0);
        apply(4'b0000, 1'b0, "err_to_idle", 0, 1, 4'h0, 2, 0, 0, 0);
        // Reverse below zero, then OFF holds the position.
        apply(4'b1001, 1'b0, "rehome_p1",   0, 1, 4'h0, 0, 1, 0, 0);
        apply(4'b1100, 1'b0, "rev_neg1",    1, 0, 4'hF, 3, 1, 0, 0);
        apply(4'b0000, 1'b0, "off_hold",    0, 0, 4'hF, 3, 0, 0, 0);
        // Mid-run asynchronous reset.
        apply(4'b1001, 1'b0, "home_again",  0, 0, 4'hF, 0, 1, 0, 0);
        apply(4'b0011, 1'b0, "step_again",  1, 1, 4'h0, 1, 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid_run", 32'(sample()), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        apply(4'b0011, 1'b0, "home_post_rst", 0, 0, 4'h0, 1, 1, 0, 0);

`ifdef SMC_DEBOUNCE_EN
        // Two-cycle glitch to the next phase must be ignored entirely.
        @(negedge clk);
        smc = 4'b0110;
        repeat (2) @(negedge clk);
        smc = 4'b0011;
        repeat (LAT + 2) @(negedge clk);
        apply(4'b0011, 1'b0, "deb_glitch",  0, 0, 4'h0, 1, 1, 0, 0);
        // A held pattern steps exactly once.
        apply(4'b0110, 1'b0, "deb_step",    1, 1, 4'h1, 2, 1, 0, 0);
        apply(4'b0110, 1'b0, "deb_hold",    0, 1, 4'h1, 2, 1, 0, 0);
`endif

        repeat (4) @(negedge clk);
        check("snap_queue_drained", 32'(snap_q.size()), 32'(0));
        check("step_queue_drained", 32'(step_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
